// File: rtl/ram_arb_pkg.sv
// Shared definitions for the main_memory port arbiter: FSM encoding and RAM geometry.
// RAM_ADDR_W/RAM_DATA_W describe the 1024x8 main_memory.
package ram_arb_pkg;

   localparam int unsigned RAM_ADDR_W = 10;
   localparam int unsigned RAM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Round-robin choice for two requesters; on a tie the port that did not go last wins.
   function automatic logic rr_choose(input logic req0, input logic req1, input logic last);
      logic sel;
      if (req0 && req1) begin
         sel = ~last;
      end else begin
         sel = req1;
      end
      return sel;
   endfunction

endpackage : ram_arb_pkg

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: sel is the winning port, any flags a pending request.
module rr_pick2
   import ram_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic sel,
   output logic any
);

   always_comb begin
      any = req0 | req1;
      sel = rr_choose(req0, req1, last);
   end

endmodule : rr_pick2

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter owning the main_memory command bus.
// One access in flight: IDLE -> ISSUE -> (read) RESP -> IDLE; writes return from ISSUE.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = RAM_ADDR_W,
   parameter int unsigned DATA_W = RAM_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state;
   arb_state_t        state_next;
   logic              last;
   logic              sel;
   logic              any;

   logic              last_d;
   logic              en_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              gnt0_d;
   logic              gnt1_d;
   logic              rvalid0_d;
   logic              rvalid1_d;

   rr_pick2 u_pick (
      .req0 (req0),
      .req1 (req1),
      .last (last),
      .sel  (sel),
      .any  (any)
   );

   assign rdata = mem_rdata;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // mem_we still holds the in-flight direction during ISSUE, so it doubles as the read/write branch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    state_next = any ? ISSUE : IDLE;
         ISSUE:   state_next = mem_we ? IDLE : RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // last doubles as the owner of the access in flight, which steers rvalid.
   always_comb begin
      last_d    = last;
      en_d      = 1'b0;
      we_d      = 1'b0;
      addr_d    = mem_addr;
      wdata_d   = mem_wdata;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               en_d    = 1'b1;
               we_d    = sel ? we1 : we0;
               addr_d  = sel ? addr1 : addr0;
               wdata_d = sel ? wdata1 : wdata0;
               gnt0_d  = ~sel;
               gnt1_d  = sel;
               last_d  = sel;
            end
         end
         ISSUE: begin
            if (!mem_we) begin
               rvalid0_d = ~last;
               rvalid1_d = last;
            end
         end
         RESP: begin
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last      <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
      end else begin
         last      <= last_d;
         mem_en    <= en_d;
         mem_we    <= we_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         gnt0      <= gnt0_d;
         gnt1      <= gnt1_d;
         rvalid0   <= rvalid0_d;
         rvalid1   <= rvalid1_d;
      end
   end

   a_gnt_onehot: assert property (@(posedge clock) disable iff (reset) !(gnt0 && gnt1));
   a_rvalid_onehot: assert property (@(posedge clock) disable iff (reset) !(rvalid0 && rvalid1));
   a_gnt_with_en: assert property (@(posedge clock) disable iff (reset) (gnt0 || gnt1) == mem_en);

endmodule : ram_port_arbiter

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural 1024x8 synchronous RAM behind it.
module tb_ram_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [AW-1:0] addr0 = '0, addr1 = '0;
   logic [DW-1:0] wdata0 = '0, wdata1 = '0;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   logic [DW-1:0] ram [0:1023];

   typedef struct {
      bit          rsp;
      bit          port;
      bit          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   failed = 0;

   always #5 clock = ~clock;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
      .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(bit rsp, bit port, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
      exp_t e;
      e.rsp = rsp; e.port = port; e.we = we; e.addr = a; e.data = d;
      return e;
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (gnt0 && gnt1) chk("gnt_both_high", 1, 0);
      if (gnt0 || gnt1) begin
         if (sb.size() == 0) chk("unexpected_gnt", {gnt1, gnt0}, 0);
         else begin
            e = sb.pop_front();
            chk("gnt_kind", 0, e.rsp);
            chk("gnt_port", gnt1, e.port);
            chk("gnt_mem_en", mem_en, 1);
            chk("gnt_mem_we", mem_we, e.we);
            chk("gnt_mem_addr", mem_addr, e.addr);
            if (e.we) chk("gnt_mem_wdata", mem_wdata, e.data);
         end
      end
      if (rvalid0 || rvalid1) begin
         if (sb.size() == 0) chk("unexpected_rvalid", {rvalid1, rvalid0}, 0);
         else begin
            e = sb.pop_front();
            chk("rvalid_kind", 1, e.rsp);
            chk("rvalid_port", rvalid1, e.port);
            chk("rvalid_rdata", rdata, e.data);
         end
      end
   end

   task automatic drive(input bit p, input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
      else   begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
   endtask

   // Single access from an idle arbiter with latency checks; scoreboard covers content.
   task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
      int n;
      bit got;
      sb.push_back(mk(0, p, we, a, wd));
      if (!we) sb.push_back(mk(1, p, 0, a, exp_rd));
      @(posedge clock); #1;
      drive(p, 1, we, a, wd);
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clock);
         n++;
         if (p ? gnt1 : gnt0) got = 1;
      end
      chk("gnt_latency", n, 2);
      if (p) req1 = 1'b0; else req0 = 1'b0;
      @(negedge clock);
      chk("cmd_one_cycle", {gnt1, gnt0, mem_we, mem_en}, 0);
      if (!we) chk("rvalid_latency", p ? rvalid1 : rvalid0, 1);
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata}, 0);
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      int n, g;
      bit got;
      #1;
      chk("reset_outputs_init", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata}, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // 1: port 0 write
      access(0, 1, 10'h005, 8'hA5, 8'h00);
      chk("ram_5_written", ram[5], 8'hA5);

      // 2: port 1 read back
      access(1, 0, 10'h005, 8'h00, 8'hA5);

      // 3: simultaneous held requests after reset alternate 0,1,0,1
      do_reset();
      sb.push_back(mk(0, 0, 1, 10'h010, 8'h11));
      sb.push_back(mk(0, 1, 1, 10'h020, 8'h22));
      sb.push_back(mk(0, 0, 1, 10'h010, 8'h11));
      sb.push_back(mk(0, 1, 1, 10'h020, 8'h22));
      @(posedge clock); #1;
      drive(0, 1, 1, 10'h010, 8'h11);
      drive(1, 1, 1, 10'h020, 8'h22);
      n = 0; g = 0;
      while (g < 4 && n < 40) begin
         @(negedge clock);
         n++;
         if (gnt0 || gnt1) g++;
         if (g == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      chk("alternate_cycles", n, 8);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clock);
      chk("ram_10", ram[10'h010], 8'h11);
      chk("ram_20", ram[10'h020], 8'h22);

      // 4: req1 raised during a port-0 read waits for IDLE
      sb.push_back(mk(0, 0, 0, 10'h010, 8'h00));
      sb.push_back(mk(1, 0, 0, 10'h010, 8'h11));
      sb.push_back(mk(0, 1, 0, 10'h020, 8'h00));
      sb.push_back(mk(1, 1, 0, 10'h020, 8'h22));
      @(posedge clock); #1;
      drive(0, 1, 0, 10'h010, 8'h00);
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clock); n++;
         if (gnt0) got = 1;
      end
      chk("t4_gnt0_latency", n, 2);
      req0 = 1'b0;
      drive(1, 1, 0, 10'h020, 8'h00);
      @(negedge clock);
      chk("t4_rvalid0", {gnt1, rvalid0}, 2'b01);
      @(negedge clock);
      chk("t4_idle_no_gnt1", gnt1, 0);
      @(negedge clock);
      chk("t4_gnt1_after_idle", gnt1, 1);
      req1 = 1'b0;
      @(negedge clock);
      chk("t4_rvalid1", rvalid1, 1);

      // 5: reset while a read sits in RESP
      sb.push_back(mk(0, 0, 0, 10'h005, 8'h00));
      @(posedge clock); #1;
      drive(0, 1, 0, 10'h005, 8'h00);
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clock); n++;
         if (gnt0) got = 1;
      end
      chk("t5_gnt0", got, 1);
      req0 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      chk("t5_reset_outputs", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, mem_addr, mem_wdata}, 0);
      repeat (2) @(negedge clock);
      chk("t5_sb_empty", sb.size(), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      access(0, 0, 10'h005, 8'h00, 8'hA5);

      // 6: top address, no wrap
      access(0, 1, 10'h3FF, 8'h7E, 8'h00);
      access(1, 0, 10'h3FF, 8'h00, 8'h7E);
      chk("ram_0_untouched_by_3ff", ram[0] === 8'h7E, 0);

      repeat (3) @(negedge clock);
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule : tb_ram_port_arbiter
